// File: rtl/wr_port_arbiter.sv
// ----------------------------------------------------------------------------
// wr_port_arbiter
//
// Round-robin arbiter sharing one decoded write-enable fan-out among eight
// requesters. One owner at a time; the owner keeps the port until it raises
// done or withdraws its request. After each release the priority pointer moves
// to the slot just past the released owner, so the released requester drops
// to lowest priority.
//
// Optional watchdog: compile with WR_ARB_TIMEOUT_EN defined to revoke any
// grant that has lasted MAX_HOLD cycles (timeout pulses for one cycle). With
// the macro undefined no hold counter exists and timeout is tied low.
//
// Parameters
//   MAX_HOLD     maximum grant length in cycles with the watchdog (2..256)
//
// Ports
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   req[7:0]     level request vector, bit i = requester i
//   done         owner finished; only looked at while a grant is active
//   grant_valid  registered: a grant is active this cycle
//   grant_addr   registered: index of the current/last owner (decoder select)
//   grant[7:0]   registered: one-hot of grant_addr while grant_valid, else 0
//   timeout      registered: one-cycle pulse when the watchdog revokes
// ----------------------------------------------------------------------------
module wr_port_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [2:0] grant_addr,
    output logic [7:0] grant,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_r, state_nx_s;
    logic [2:0] ptr_r, ptr_nx_s;
    logic [2:0] addr_r, addr_nx_s;
    logic       valid_r, valid_nx_s;
    logic [7:0] grant_r, grant_nx_s;
    logic       timeout_r, timeout_nx_s;

    logic [2:0] pick_s;
    logic       release_s;
    logic       hold_exp_s;

    // Reject out-of-range hold limits when the block is elaborated.
    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("wr_port_arbiter: MAX_HOLD must be in 2..256");
    end

    // One-hot expansion of a 3-bit index.
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'h01 << idx;
    endfunction

    // First set request scanning p, p+1, ..., wrapping modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = p + 3'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

    assign pick_s    = rr_pick(req, ptr_r);
    // done and a dropped owner request are the same event; both together
    // still produce a single release.
    assign release_s = done | ~req[addr_r];

`ifdef WR_ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_r;
    logic [HW-1:0] hold_nx_s;

    // Counter is zero on the entry edge and counts edges spent in GRANT, so
    // reaching MAX_HOLD-1 means the grant has been visible MAX_HOLD cycles.
    assign hold_exp_s = (state_r == GRANT) && (hold_r == HW'(MAX_HOLD - 1));

    // Hold counter next value: cleared outside GRANT, incremented inside.
    always_comb begin
        hold_nx_s = '0;
        if (state_r == GRANT) begin
            hold_nx_s = hold_r + HW'(1);
        end else begin
            hold_nx_s = '0;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_r <= '0;
        end else begin
            hold_r <= hold_nx_s;
        end
    end
`else
    assign hold_exp_s = 1'b0;
`endif

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_nx_s   = state_r;
        ptr_nx_s     = ptr_r;
        addr_nx_s    = addr_r;
        valid_nx_s   = valid_r;
        grant_nx_s   = grant_r;
        timeout_nx_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req != 8'h00) begin
                    state_nx_s = GRANT;
                    addr_nx_s  = pick_s;
                    valid_nx_s = 1'b1;
                    grant_nx_s = onehot8(pick_s);
                end else begin
                    valid_nx_s = 1'b0;
                    grant_nx_s = 8'h00;
                end
            end
            GRANT: begin
                if (release_s || hold_exp_s) begin
                    state_nx_s   = IDLE;
                    valid_nx_s   = 1'b0;
                    grant_nx_s   = 8'h00;
                    ptr_nx_s     = addr_r + 3'd1;
                    // A normal release on the same edge wins: no timeout.
                    timeout_nx_s = ~release_s;
                end else begin
                    valid_nx_s = 1'b1;
                    grant_nx_s = onehot8(addr_r);
                end
            end
            default: begin
                state_nx_s = IDLE;
                valid_nx_s = 1'b0;
                grant_nx_s = 8'h00;
            end
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ptr_r     <= 3'd0;
            addr_r    <= 3'd0;
            valid_r   <= 1'b0;
            grant_r   <= 8'h00;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            ptr_r     <= ptr_nx_s;
            addr_r    <= addr_nx_s;
            valid_r   <= valid_nx_s;
            grant_r   <= grant_nx_s;
            timeout_r <= timeout_nx_s;
        end
    end

    assign grant_valid = valid_r;
    assign grant_addr  = addr_r;
    assign grant       = grant_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wr_port_arbiter
//
// Self-checking bench for wr_port_arbiter. A cycle-level behavioural model
// (owner index, pointer, cycles-held count) predicts the outputs after every
// clock edge; directed sequences cover reset, the round-robin sweep, wrap
// fairness, request withdrawal and the watchdog (present or absent according
// to WR_ARB_TIMEOUT_EN), followed by randomized traffic.
// ----------------------------------------------------------------------------
module tb_wr_port_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_addr;
    logic [7:0] grant;
    logic       timeout;

    int n_checks;
    int n_pass;

    // Reference model state
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;   // cycles the current grant has been visible
    bit m_to;

    wr_port_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_addr  (grant_addr),
        .grant       (grant),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    // Behaviour of one clock edge, from the arbitration rules.
    task automatic model_edge(input logic [7:0] r, input logic d);
        m_to = 1'b0;
        if (!m_busy) begin
            if (r != 8'h00) begin
                for (int k = 7; k >= 0; k--) begin
                    if (r[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
                end
                m_busy = 1'b1;
                m_hold = 1;
            end
        end else if (d || !r[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % 8;
        end
`ifdef WR_ARB_TIMEOUT_EN
        else if (m_hold == MAX_HOLD) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % 8;
            m_to   = 1'b1;
        end
`endif
        else begin
            m_hold++;
        end
    endtask

    task automatic check_outputs();
        logic [7:0] exp_grant;
        logic [7:0] owner8;
        exp_grant = 8'h00;
        owner8    = 8'(m_owner);
        if (m_busy) exp_grant = 8'h01 << owner8[2:0];
        check("grant_valid", {7'd0, grant_valid}, {7'd0, m_busy});
        check("grant_addr",  {5'd0, grant_addr},  owner8);
        check("grant",       grant,               exp_grant);
        check("timeout",     {7'd0, timeout},     {7'd0, m_to});
    endtask

    task automatic step(input logic [7:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [7:0] rv;
        logic       dv;
        int         cnt_valid;
        int         cnt_to;
        int         to_at;

        n_checks = 0;
        n_pass   = 0;
        model_reset();
        req   = 8'h00;
        done  = 1'b0;
        rst_n = 1'b0;
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin sweep: done on each grant's first cycle
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b1);
            check("sweep_valid", {7'd0, grant_valid}, 8'd1);
            check("sweep_addr", {5'd0, grant_addr}, 8'(i % 8));
            step(8'hFF, 1'b1);
            check("sweep_dead", {7'd0, grant_valid}, 8'd0);
        end

        // Wrap fairness: serve 5 (ptr -> 6), then 0x81 alternates 7,0,7
        step(8'h20, 1'b0);
        step(8'h20, 1'b1);
        step(8'h81, 1'b0);
        check("wrap_first", {5'd0, grant_addr}, 8'd7);
        step(8'h81, 1'b1);
        step(8'h81, 1'b0);
        check("wrap_second", {5'd0, grant_addr}, 8'd0);
        step(8'h81, 1'b1);
        step(8'h81, 1'b0);
        check("wrap_third", {5'd0, grant_addr}, 8'd7);
        step(8'h81, 1'b1);

        // Withdrawal: dropping req[2] releases and moves ptr to 3
        step(8'h04, 1'b0);
        step(8'h00, 1'b0);
        check("withdraw_release", {7'd0, grant_valid}, 8'd0);
        step(8'h0C, 1'b0);
        check("withdraw_ptr", {5'd0, grant_addr}, 8'd3);
        step(8'h0C, 1'b1);
        step(8'h04, 1'b0);
        step(8'h00, 1'b1);
        step(8'h00, 1'b0);
        check("single_release", {7'd0, grant_valid}, 8'd0);

        // Asynchronous reset in the middle of a grant to 4
        step(8'h10, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2 rst_n = 1'b1;
        step(8'h10, 1'b0);
        check("post_reset_grant", grant, 8'h10);
        step(8'h10, 1'b1);

        // Watchdog behaviour with a stuck owner on requester 0
        cnt_valid = 0;
        cnt_to    = 0;
        to_at     = 0;
`ifdef WR_ARB_TIMEOUT_EN
        for (int i = 1; i <= 12; i++) begin
            step(8'h01, 1'b0);
            if (grant_valid) cnt_valid++;
            if (timeout) begin
                cnt_to++;
                if (to_at == 0) to_at = i;
            end
        end
        check("wd_first_timeout", 8'(to_at), 8'd5);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(8'h01, 1'b0);
        step(8'h01, 1'b1);
        check("wd_done_wins", {7'd0, timeout}, 8'd0);
        step(8'h00, 1'b0);
`else
        step(8'h01, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            step(8'h01, 1'b0);
            if (grant_valid) cnt_valid++;
            if (timeout) cnt_to++;
        end
        check("nowd_held_low", 8'(cnt_valid % 256), 8'(1000 % 256));
        check("nowd_held_high", 8'(cnt_valid / 256), 8'(1000 / 256));
        check("nowd_timeout", 8'(cnt_to), 8'd0);
        step(8'h01, 1'b1);
`endif

        // Randomized traffic: requests accumulate and are held until served
        rv = 8'h00;
        for (int i = 0; i < 2000; i++) begin
            dv = 1'b0;
            rv = rv | (8'($urandom) & 8'($urandom) & 8'($urandom));
            if (m_busy && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) dv = 1'b1;
                if ($urandom_range(0, 2) != 0) rv[m_owner] = 1'b0;
            end
            step(rv, dv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wr_port_arbiter.md
# wr_port_arbiter

Round-robin arbiter that shares one decoded write-enable fan-out among eight requesters in the processor datapath. It selects one requester at a time and drives the 3-bit select consumed by the 1-to-8 one-hot decoder. It also presents the equivalent one-hot grant and holds it until the owner signals completion. Ownership rotates fairly, and an optional watchdog stops a stuck owner from holding the port indefinitely.

## Interface
- MAX_HOLD, 16: maximum cycles one grant may last when the watchdog is compiled in; legal range 2..256.

- clk  input  1  rising-edge system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request vector; bit i = requester i wants the port; level, held until served
- done  input  1  owner finished; sampled only while a grant is active
- grant_valid  output  1  a grant is active this cycle
- grant_addr  output  3  index of current owner; decoder select
- grant  output  8  one-hot grant, equal to 8'h01 << grant_addr when grant_valid, else 8'h00
- timeout  output  1  one-cycle pulse: grant revoked by watchdog

## Operation
- State machine with two states, IDLE and GRANT. A 3-bit priority pointer ptr is also kept.
- All outputs are registered. Reset values:
  - state = IDLE, ptr = 0, grant_valid = 0, grant_addr = 0, grant = 8'h00, timeout = 0.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise choose the first set bit scanning ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8).
  - Load that index into grant_addr and go to GRANT.
- GRANT:
  - grant_valid = 1 and grant is the one-hot of grant_addr.
  - Release when done = 1 OR req[grant_addr] = 0 at the clock edge.
  - On release: go to IDLE, grant_valid and grant go to 0, and ptr is set to grant_addr + 1 (7 wraps to 0).
  - grant_addr keeps its last value while idle.
- Requests from other requesters during GRANT are ignored until the next arbitration. There is no preemption.
- done sampled in IDLE is ignored.
- done and a drop of req[grant_addr] in the same cycle count as a single release.
- A reset asserted mid-grant clears all outputs and state immediately (asynchronously). Arbitration restarts from ptr = 0.
- If the requester just released still has req asserted, it gets the lowest priority at the next arbitration. It is granted again only if no other bit is set.

## Timing
- Grant latency: req seen at edge N in IDLE → grant_valid = 1 from edge N (visible in cycle N+1).
- Release: done = 1 at edge K → grant_valid = 0 from edge K.
- Turnaround: the earliest next grant is at edge K+1. Exactly one dead cycle separates consecutive grants.
- Minimum grant length is one cycle: done = 1 at the first edge in GRANT.
- Maximum sustained throughput is one grant per 2 cycles.
- timeout rises on the revoking edge and clears on the next edge.

## Configuration
- Macro WR_ARB_TIMEOUT_EN.
- When defined:
  - A hold counter (width clog2(MAX_HOLD)) clears on entry to GRANT and increments on each edge spent in GRANT.
  - When the counter equals MAX_HOLD-1 at an edge with no release, the grant is revoked exactly as a normal release (ptr advances) and timeout pulses high for one cycle.
  - No grant lasts more than MAX_HOLD cycles.
  - A normal release on the same edge takes precedence, and timeout stays 0.
- When undefined: no counter is built, timeout is tied to 0, and a grant lasts until done or until req[grant_addr] drops. MAX_HOLD is unused.

## Test plan
- Reset and idle: assert rst_n = 0 mid-grant with req = 8'h10 → all outputs 0 asynchronously. After release, req = 8'h10 → grant_addr = 4, grant = 8'h10 one cycle later.
- Round-robin sweep: hold req = 8'hFF and pulse done on every grant's first cycle → grant_addr sequence is 0,1,…,7,0 with grant_valid pattern 1,0,1,0…
- Fairness with wrap: ptr = 6 after serving 5, req = 8'h81 → grant 7, then 0, then 7 again (repeat 0 only after 7).
- Request withdrawal: grant to 2, drop req[2] with done = 0 → grant_valid falls on that edge and ptr = 3. Simultaneous done and req drop → single release, no extra grant.
- Watchdog (WR_ARB_TIMEOUT_EN, MAX_HOLD = 4): req = 8'h01 held, done never asserted → grant_valid high for exactly 4 cycles, then timeout = 1 for one cycle and a regrant after one dead cycle. Done on the 4th cycle → timeout stays 0.
- Watchdog absent: same stimulus → grant held for 1000 cycles and timeout constantly 0.
